// File: rtl/reloj_bcd.sv
// 24-hour BCD clock: prescaled 1 Hz timekeeping with a manual set mode whose
// per-field increment buttons are rising-edge detected.
module reloj_bcd #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       set_mode,
  input  logic       inc_seg,
  input  logic       inc_min,
  input  logic       inc_hora,
  output logic [3:0] SegundosU,
  output logic [3:0] SegundosD,
  output logic [3:0] minutosU,
  output logic [3:0] minutosD,
  output logic [3:0] horasU,
  output logic [3:0] horasD,
  output logic       tick_1hz,
  output logic       update
);

  localparam int unsigned PresW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSet} state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic             tick_q, tick_d, update_q, update_d;
  logic [2:0]       inc_prev_q, inc_edge;

  // {tens, units} BCD increment with wrap; callers handle carries themselves.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StIdle;
    if (set_mode)  state_d = StSet;
    else if (en)   state_d = StRun;
  end

  // bit 0 = seconds, 1 = minutes, 2 = hours
  assign inc_edge = {inc_hora, inc_min, inc_seg} & ~inc_prev_q;

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (presc_q == PresLast) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sec_d   = inc60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc60(min_q);
            if (min_q == 8'h59) hour_d = inc24(hour_q);
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end
      end
      StSet: begin
        presc_d = '0;
        if (inc_edge[0]) sec_d  = inc60(sec_q);
        if (inc_edge[1]) min_d  = inc60(min_q);
        if (inc_edge[2]) hour_d = inc24(hour_q);
      end
      default: ;
    endcase
    update_d = ({hour_d, min_d, sec_d} != {hour_q, min_q, sec_q});
  end

  // Delayed copies reset high so buttons held through reset never count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      tick_q     <= 1'b0;
      update_q   <= 1'b0;
      inc_prev_q <= 3'b111;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tick_q     <= tick_d;
      update_q   <= update_d;
      inc_prev_q <= {inc_hora, inc_min, inc_seg};
    end
  end

  assign SegundosU = sec_q[3:0];
  assign SegundosD = sec_q[7:4];
  assign minutosU  = min_q[3:0];
  assign minutosD  = min_q[7:4];
  assign horasU    = hour_q[3:0];
  assign horasD    = hour_q[7:4];
  assign tick_1hz  = tick_q;
  assign update    = update_q;

endmodule
